// File: rtl/code_memory_loader.sv
// Code memory writer: receives a nibble-stream program image, assembles and writes
// instruction words from address 0, and holds the CPU in reset until the image verifies.
module code_memory_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_start,
  input  logic              in_valid,
  input  logic [3:0]        in_nibble,
  output logic              out_ready,
  output logic              out_mem_wr_en,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic [DATA_W-1:0] out_mem_data,
  output logic              out_cpu_hold,
  output logic              out_done,
  output logic              out_error
);

  localparam int NPW   = DATA_W / 4;
  localparam int NIB_W = (NPW > 1) ? $clog2(NPW) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          hdr_cnt_q, hdr_cnt_d;
  logic [11:0]         count_q, count_d;
  logic [NIB_W-1:0]    nib_cnt_q, nib_cnt_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [3:0]          chk_q, chk_d;
  logic                ready_q, ready_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                fire_s;
  logic [11:0]         count_new_s;
  logic [DATA_W-1:0]   word_new_s;
  logic                word_last_s;
  logic                count_bad_s;

  // Running checksum: XOR over every data nibble.
  function automatic logic [3:0] chk_update(input logic [3:0] acc, input logic [3:0] nib);
    return acc ^ nib;
  endfunction

  assign fire_s      = in_valid & ready_q;
  assign count_new_s = {count_q[7:0], in_nibble};
  assign word_new_s  = (word_q << 4) | DATA_W'(in_nibble);
  assign word_last_s = (16'(idx_q) == (16'(count_q) - 16'd1));
  assign count_bad_s = (count_new_s == 12'd0) || (32'(count_new_s) > 32'(DEPTH));

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    count_d   = count_q;
    nib_cnt_d = nib_cnt_q;
    word_d    = word_q;
    idx_d     = idx_q;
    chk_d     = chk_q;
    wr_en_d   = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (in_start) begin
          state_d   = S_HDR;
          hdr_cnt_d = 2'd0;
          count_d   = 12'd0;
          nib_cnt_d = '0;
          word_d    = '0;
          idx_d     = '0;
          chk_d     = 4'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_HDR: begin
        if (fire_s) begin
          count_d = count_new_s;
          if (hdr_cnt_q == 2'd2) begin
            hdr_cnt_d = 2'd0;
            state_d   = count_bad_s ? S_ERR : S_DATA;
          end else begin
            hdr_cnt_d = hdr_cnt_q + 2'd1;
          end
        end else begin
          state_d = S_HDR;
        end
      end
      S_DATA: begin
        if (fire_s) begin
          chk_d  = chk_update(chk_q, in_nibble);
          word_d = word_new_s;
          if (nib_cnt_q == NIB_W'(NPW - 1)) begin
            nib_cnt_d = '0;
            wr_en_d   = 1'b1;
            addr_d    = idx_q;
            data_d    = word_new_s;
            // Index stops at N-1 so the address can never wrap on a full image.
            if (word_last_s) begin
              state_d = S_CHK;
            end else begin
              idx_d = idx_q + ADDR_W'(1);
            end
          end else begin
            nib_cnt_d = nib_cnt_q + NIB_W'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHK: begin
        if (fire_s) begin
          state_d = (in_nibble == chk_q) ? S_DONE : S_ERR;
        end else begin
          state_d = S_CHK;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CHK);
    hold_d  = (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERR);
  end

  // State and output registers; reset drops any write strobe in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hdr_cnt_q <= 2'd0;
      count_q   <= 12'd0;
      nib_cnt_q <= '0;
      word_q    <= '0;
      idx_q     <= '0;
      chk_q     <= 4'd0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      count_q   <= count_d;
      nib_cnt_q <= nib_cnt_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign out_ready     = ready_q;
  assign out_mem_wr_en = wr_en_q;
  assign out_mem_addr  = addr_q;
  assign out_mem_data  = data_q;
  assign out_cpu_hold  = hold_q;
  assign out_done      = done_q;
  assign out_error     = error_q;

endmodule

// File: tb/tb_code_memory_loader.sv
// Directed bench for code_memory_loader: table of image streams plus hand-written
// sequences for the full-depth image and a reset in the middle of a load.
module tb_code_memory_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_nibble = 4'd0;
  logic        out_ready, out_mem_wr_en, out_cpu_hold, out_done, out_error;
  logic [8:0]  out_mem_addr;
  logic [15:0] out_mem_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0]  wr_addr[$];
  logic [15:0] wr_data[$];

  code_memory_loader #(.ADDR_W(9), .DATA_W(16), .DEPTH(512)) dut (
    .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_valid(in_valid),
    .in_nibble(in_nibble), .out_ready(out_ready), .out_mem_wr_en(out_mem_wr_en),
    .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data),
    .out_cpu_hold(out_cpu_hold), .out_done(out_done), .out_error(out_error)
  );

  always #5 clk = ~clk;

  // Every strobe-high cycle is logged, so a stretched strobe shows up as an extra write.
  always @(negedge clk) begin
    if (out_mem_wr_en === 1'b1) begin
      wr_addr.push_back(out_mem_addr);
      wr_data.push_back(out_mem_data);
    end
  end

  typedef struct packed {
    logic [63:0] nibs;       // stream, first nibble in bits 63:60
    logic [4:0]  len;
    logic        gaps;
    logic        exp_done;
    logic        exp_err;
    logic [1:0]  exp_nw;
    logic [31:0] exp_words;  // word 0 in bits 31:16
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_nib(input logic [3:0] n, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    in_valid  = 1'b1;
    in_nibble = n;
    t = 0;
    while (out_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: out_ready low for %0d cycles, expected 1", t);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    in_start = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int gap;
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    check($sformatf("v%0d_start_hold", k), {31'd0, out_cpu_hold}, 32'd1);
    check($sformatf("v%0d_start_done", k), {31'd0, out_done}, 32'd0);
    for (int i = 0; i < int'(v.len); i++) begin
      gap = v.gaps ? int'($urandom_range(5, 0)) : 0;
      send_nib(v.nibs[63 - 4*i -: 4], gap);
    end
    repeat (3) @(negedge clk);
    check($sformatf("v%0d_done", k), {31'd0, out_done}, {31'd0, v.exp_done});
    check($sformatf("v%0d_error", k), {31'd0, out_error}, {31'd0, v.exp_err});
    check($sformatf("v%0d_hold", k), {31'd0, out_cpu_hold}, {31'd0, ~v.exp_done});
    check($sformatf("v%0d_nwrites", k), 32'(wr_addr.size()), {30'd0, v.exp_nw});
    for (int i = 0; i < int'(v.exp_nw) && i < wr_addr.size(); i++) begin
      check($sformatf("v%0d_addr%0d", k, i), {23'd0, wr_addr[i]}, 32'(i));
      check($sformatf("v%0d_data%0d", k, i), {16'd0, wr_data[i]}, {16'd0, v.exp_words[31 - 16*i -: 16]});
    end
  endtask

  initial begin
    int bad_seq;
    // T1 / T2 / T3 / T4 / re-load / T5 gaps / single-word pass and fail
    vecs[0] = '{nibs: 64'h0021234ABCD40000, len: 5'd12, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_nw: 2'd2, exp_words: 32'h1234ABCD};
    vecs[1] = '{nibs: 64'h0000000000000000, len: 5'd3,  gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_nw: 2'd0, exp_words: 32'h0};
    vecs[2] = '{nibs: 64'h2010000000000000, len: 5'd3,  gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_nw: 2'd0, exp_words: 32'h0};
    vecs[3] = '{nibs: 64'h0021234ABCD50000, len: 5'd12, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_nw: 2'd2, exp_words: 32'h1234ABCD};
    vecs[4] = '{nibs: 64'h0021234ABCD40000, len: 5'd12, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_nw: 2'd2, exp_words: 32'h1234ABCD};
    vecs[5] = '{nibs: 64'h0021234ABCD40000, len: 5'd12, gaps: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_nw: 2'd2, exp_words: 32'h1234ABCD};
    vecs[6] = '{nibs: 64'h001F00F000000000, len: 5'd8,  gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_nw: 2'd1, exp_words: 32'hF00F0000};
    vecs[7] = '{nibs: 64'h001F00F100000000, len: 5'd8,  gaps: 1'b1, exp_done: 1'b0, exp_err: 1'b1, exp_nw: 2'd1, exp_words: 32'hF00F0000};

    #12;
    check("rst_ready", {31'd0, out_ready}, 32'd0);
    check("rst_wr_en", {31'd0, out_mem_wr_en}, 32'd0);
    check("rst_addr", {23'd0, out_mem_addr}, 32'd0);
    check("rst_data", {16'd0, out_mem_data}, 32'd0);
    check("rst_hold", {31'd0, out_cpu_hold}, 32'd1);
    check("rst_done", {31'd0, out_done}, 32'd0);
    check("rst_error", {31'd0, out_error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      run_vec(k, vecs[k]);
    end

    // T3b: full-depth image of 512 zero words, checksum 0.
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    send_nib(4'h2, 0);
    send_nib(4'h0, 0);
    send_nib(4'h0, 0);
    for (int i = 0; i < 2048; i++) send_nib(4'h0, 0);
    send_nib(4'h0, 0);
    repeat (3) @(negedge clk);
    check("full_nwrites", 32'(wr_addr.size()), 32'd512);
    if (wr_addr.size() > 0) check("full_last_addr", {23'd0, wr_addr[wr_addr.size()-1]}, 32'h1FF);
    bad_seq = 0;
    for (int i = 0; i < wr_addr.size(); i++) begin
      if (wr_addr[i] !== 9'(i) || wr_data[i] !== 16'h0000) bad_seq++;
    end
    check("full_addr_data_seq", 32'(bad_seq), 32'd0);
    check("full_done", {31'd0, out_done}, 32'd1);
    check("full_hold", {31'd0, out_cpu_hold}, 32'd0);

    // T6: reset after six data nibbles, then a clean load.
    pulse_start();
    send_nib(4'h0, 0);
    send_nib(4'h0, 0);
    send_nib(4'h2, 0);
    send_nib(4'h1, 0);
    send_nib(4'h2, 0);
    send_nib(4'h3, 0);
    send_nib(4'h4, 0);
    send_nib(4'hA, 0);
    send_nib(4'hB, 0);
    check("mid_hold_before_rst", {31'd0, out_cpu_hold}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, out_ready}, 32'd0);
    check("mid_rst_wr_en", {31'd0, out_mem_wr_en}, 32'd0);
    check("mid_rst_addr", {23'd0, out_mem_addr}, 32'd0);
    check("mid_rst_data", {16'd0, out_mem_data}, 32'd0);
    check("mid_rst_hold", {31'd0, out_cpu_hold}, 32'd1);
    check("mid_rst_done", {31'd0, out_done}, 32'd0);
    check("mid_rst_error", {31'd0, out_error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(8, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
